// File: rtl/countrate_pkg.sv
// Shared types and helpers for the countrate acquisition sequencer.
package countrate_pkg;

  localparam int unsigned DEF_WINDOW_WIDTH    = 64;
  localparam int unsigned DEF_NUM_OF_CHANNELS = 4;
  localparam int unsigned DEF_COUNTER_WIDTH   = 32;
  localparam int unsigned DEF_NWIN_WIDTH      = 16;
  localparam int unsigned DEF_CH_IDX_W        =
    (DEF_NUM_OF_CHANNELS > 1) ? $clog2(DEF_NUM_OF_CHANNELS) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_START,
    ST_RUN,
    ST_FLUSH
  } state_t;

  // Channel idx out of the flattened count vector (channel 0 in the LSBs).
  function automatic logic [DEF_COUNTER_WIDTH-1:0] channel_count(
    input logic [DEF_NUM_OF_CHANNELS*DEF_COUNTER_WIDTH-1:0] data,
    input logic [DEF_CH_IDX_W-1:0]                          idx
  );
    logic [DEF_COUNTER_WIDTH-1:0] res;
    res = '0;
    for (int unsigned i = 0; i < DEF_NUM_OF_CHANNELS; i++) begin
      if (idx == DEF_CH_IDX_W'(i)) res = data[i*DEF_COUNTER_WIDTH +: DEF_COUNTER_WIDTH];
    end
    return res;
  endfunction

endpackage

// File: rtl/countrate_ctrl_snapshot_ser.sv
// Single-entry snapshot buffer that streams one window's channel counts
// out as valid/ready words, channel 0 first.
module countrate_snapshot_ser
  import countrate_pkg::*;
#(
  parameter int unsigned NUM_OF_CHANNELS = DEF_NUM_OF_CHANNELS,
  parameter int unsigned COUNTER_WIDTH   = DEF_COUNTER_WIDTH,
  parameter int unsigned NWIN_WIDTH      = DEF_NWIN_WIDTH,
  parameter int unsigned CH_IDX_W        = (NUM_OF_CHANNELS > 1) ? $clog2(NUM_OF_CHANNELS) : 1
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     capture,
  input  logic [NUM_OF_CHANNELS*COUNTER_WIDTH-1:0] cap_data,
  input  logic [NWIN_WIDTH-1:0]                    cap_idx,
  input  logic                                     m_ready,
  output logic                                     m_valid,
  output logic [COUNTER_WIDTH-1:0]                 m_data,
  output logic [CH_IDX_W-1:0]                      m_channel,
  output logic [NWIN_WIDTH-1:0]                    m_window_idx,
  output logic                                     m_last,
  output logic                                     free_c
);

  localparam int unsigned DATA_W = NUM_OF_CHANNELS * COUNTER_WIDTH;
  localparam logic [CH_IDX_W-1:0] LAST_CH = CH_IDX_W'(NUM_OF_CHANNELS - 1);

  logic [DATA_W-1:0]   snap;
  logic [CH_IDX_W-1:0] ch_nxt;
  logic                hs;

  assign hs     = m_valid && m_ready;
  assign ch_nxt = m_channel + 1'b1;
  // The buffer is reusable in the same cycle its last word is accepted.
  assign free_c = !m_valid || (hs && m_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap         <= '0;
      m_valid      <= 1'b0;
      m_data       <= '0;
      m_channel    <= '0;
      m_window_idx <= '0;
      m_last       <= 1'b0;
    end else if (capture) begin
      snap         <= cap_data;
      m_valid      <= 1'b1;
      m_data       <= channel_count(cap_data, '0);
      m_channel    <= '0;
      m_window_idx <= cap_idx;
      m_last       <= (LAST_CH == '0);
    end else if (hs) begin
      if (m_last) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end else begin
        m_channel <= ch_nxt;
        m_data    <= channel_count(snap, ch_nxt);
        m_last    <= (ch_nxt == LAST_CH);
      end
    end
  end

endmodule

// File: rtl/countrate_ctrl.sv
// Acquisition sequencer for countrate: latches window config, pulses
// reset/start to the counter, counts windows and serialises their counts.
module countrate_ctrl
  import countrate_pkg::*;
#(
  parameter int unsigned WINDOW_WIDTH    = DEF_WINDOW_WIDTH,
  parameter int unsigned NUM_OF_CHANNELS = DEF_NUM_OF_CHANNELS,
  parameter int unsigned COUNTER_WIDTH   = DEF_COUNTER_WIDTH,
  parameter int unsigned NWIN_WIDTH      = DEF_NWIN_WIDTH,
  parameter int unsigned CH_IDX_W        = (NUM_OF_CHANNELS > 1) ? $clog2(NUM_OF_CHANNELS) : 1
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [WINDOW_WIDTH-1:0]                  cfg_window_size,
  input  logic [NWIN_WIDTH-1:0]                    cfg_num_windows,
  input  logic                                     cmd_start,
  input  logic                                     cmd_stop,
  output logic [WINDOW_WIDTH-1:0]                  window_size,
  output logic                                     start_counting,
  output logic                                     reset_counting,
  input  logic                                     count_valid,
  input  logic [NUM_OF_CHANNELS*COUNTER_WIDTH-1:0] count_data,
  output logic                                     m_valid,
  input  logic                                     m_ready,
  output logic [COUNTER_WIDTH-1:0]                 m_data,
  output logic [CH_IDX_W-1:0]                      m_channel,
  output logic [NWIN_WIDTH-1:0]                    m_window_idx,
  output logic                                     m_last,
  output logic                                     busy,
  output logic                                     overrun,
  output logic                                     cfg_err
);

  state_t                  state, state_nxt;
  logic [WINDOW_WIDTH-1:0] window_size_nxt;
  logic [NWIN_WIDTH-1:0]   num_windows, num_windows_nxt;
  logic [NWIN_WIDTH-1:0]   win_cnt, win_cnt_nxt;
  logic                    overrun_nxt, cfg_err_nxt;
  logic                    reset_counting_nxt, start_counting_nxt, busy_nxt;
  logic                    capture_c, free_c;

  // Next-state, config latch, window counting and sticky flags.
  always_comb begin
    state_nxt       = state;
    window_size_nxt = window_size;
    num_windows_nxt = num_windows;
    win_cnt_nxt     = win_cnt;
    overrun_nxt     = overrun;
    cfg_err_nxt     = cfg_err;
    capture_c       = 1'b0;

    case (state)
      ST_IDLE: begin
        if (cmd_start) begin
          if (cfg_window_size != '0) begin
            state_nxt       = ST_ARM;
            window_size_nxt = cfg_window_size;
            num_windows_nxt = cfg_num_windows;
            win_cnt_nxt     = '0;
            overrun_nxt     = 1'b0;
            cfg_err_nxt     = 1'b0;
          end else begin
            cfg_err_nxt = 1'b1;
          end
        end
      end
      ST_ARM:   state_nxt = ST_START;
      ST_START: state_nxt = ST_RUN;
      ST_RUN: begin
        // A window arriving with stop is still captured and counted.
        if (count_valid) begin
          win_cnt_nxt = win_cnt + 1'b1;
          if (free_c) capture_c   = 1'b1;
          else        overrun_nxt = 1'b1;
        end
        if (cmd_stop ||
            (count_valid && (num_windows != '0) && (win_cnt_nxt == num_windows)))
          state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (free_c) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase

    reset_counting_nxt = (state_nxt == ST_ARM) ||
                         ((state == ST_RUN) && (state_nxt == ST_FLUSH));
    start_counting_nxt = (state_nxt == ST_START);
    busy_nxt           = (state_nxt != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      window_size    <= '0;
      num_windows    <= '0;
      win_cnt        <= '0;
      overrun        <= 1'b0;
      cfg_err        <= 1'b0;
      reset_counting <= 1'b0;
      start_counting <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state          <= state_nxt;
      window_size    <= window_size_nxt;
      num_windows    <= num_windows_nxt;
      win_cnt        <= win_cnt_nxt;
      overrun        <= overrun_nxt;
      cfg_err        <= cfg_err_nxt;
      reset_counting <= reset_counting_nxt;
      start_counting <= start_counting_nxt;
      busy           <= busy_nxt;
    end
  end

  countrate_snapshot_ser #(
    .NUM_OF_CHANNELS (NUM_OF_CHANNELS),
    .COUNTER_WIDTH   (COUNTER_WIDTH),
    .NWIN_WIDTH      (NWIN_WIDTH),
    .CH_IDX_W        (CH_IDX_W)
  ) u_ser (
    .clk          (clk),
    .rst_n        (rst_n),
    .capture      (capture_c),
    .cap_data     (count_data),
    .cap_idx      (win_cnt),
    .m_ready      (m_ready),
    .m_valid      (m_valid),
    .m_data       (m_data),
    .m_channel    (m_channel),
    .m_window_idx (m_window_idx),
    .m_last       (m_last),
    .free_c       (free_c)
  );

endmodule

// File: tb/tb_countrate_ctrl.sv
// Self-checking bench for countrate_ctrl: scenario tasks against a
// word-level reference model of window capture and readout.
module tb_countrate_ctrl;

  localparam int unsigned WW  = 64;
  localparam int unsigned NC  = 4;
  localparam int unsigned CW  = 32;
  localparam int unsigned NW  = 16;
  localparam int unsigned CIW = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WW-1:0]    cfg_window_size = '0;
  logic [NW-1:0]    cfg_num_windows = '0;
  logic             cmd_start = 1'b0;
  logic             cmd_stop = 1'b0;
  logic             count_valid = 1'b0;
  logic [NC*CW-1:0] count_data = '0;
  logic             m_ready = 1'b0;
  logic [WW-1:0]    window_size;
  logic             start_counting, reset_counting;
  logic             m_valid, m_last, busy, overrun, cfg_err;
  logic [CW-1:0]    m_data;
  logic [CIW-1:0]   m_channel;
  logic [NW-1:0]    m_window_idx;

  int          checks = 0;
  int          failures = 0;
  int unsigned cyc = 0;
  bit          rand_ready = 1'b0;

  // Reference model: expected words, observed words, pulse timestamps.
  logic [63:0] exp_q[$];
  logic [63:0] obs_q[$];
  int unsigned rc_q[$];
  int unsigned sc_q[$];
  bit          model_run = 1'b0;
  bit          model_ovr = 1'b0;
  int unsigned model_num = 0;
  int unsigned model_win = 0;
  int unsigned model_rem = 0;

  countrate_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cfg_window_size (cfg_window_size),
    .cfg_num_windows (cfg_num_windows),
    .cmd_start       (cmd_start),
    .cmd_stop        (cmd_stop),
    .window_size     (window_size),
    .start_counting  (start_counting),
    .reset_counting  (reset_counting),
    .count_valid     (count_valid),
    .count_data      (count_data),
    .m_valid         (m_valid),
    .m_ready         (m_ready),
    .m_data          (m_data),
    .m_channel       (m_channel),
    .m_window_idx    (m_window_idx),
    .m_last          (m_last),
    .busy            (busy),
    .overrun         (overrun),
    .cfg_err         (cfg_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    if (rand_ready) m_ready = 1'($urandom_range(0, 1));
  end

  // Word key: {data, channel, window index, last}.
  function automatic logic [63:0] wkey(input logic [31:0] d, input int unsigned ch,
                                       input int unsigned idx, input logic last);
    return {d, 8'(ch), 16'(idx), 7'd0, last};
  endfunction

  // Observe outputs and advance the model for the coming edge.
  always @(negedge clk) begin : model_b
    bit hs;
    if (rst_n) begin
      if (m_valid && m_ready)
        obs_q.push_back(wkey(m_data, 32'(m_channel), 32'(m_window_idx), m_last));
      if (reset_counting) rc_q.push_back(cyc);
      if (start_counting) sc_q.push_back(cyc);
      hs = (model_rem > 0) && m_ready;
      if (model_run && count_valid) begin
        if (model_rem == 0 || (model_rem == 1 && hs)) begin
          for (int c = 0; c < int'(NC); c++)
            exp_q.push_back(wkey(count_data[c*CW +: CW], 32'(c), model_win % 65536,
                                 c == int'(NC) - 1));
          model_rem = NC;
        end else begin
          model_ovr = 1'b1;
          if (hs) model_rem--;
        end
        model_win++;
        if (model_num != 0 && model_win == model_num) model_run = 1'b0;
      end else if (hs) begin
        model_rem--;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_model();
    exp_q.delete(); obs_q.delete(); rc_q.delete(); sc_q.delete();
    model_run = 1'b0; model_ovr = 1'b0; model_num = 0; model_win = 0; model_rem = 0;
  endtask

  task automatic start_acq(input logic [WW-1:0] size, input int unsigned num,
                           output int unsigned t);
    cfg_window_size = size;
    cfg_num_windows = NW'(num);
    cmd_start = 1'b1;
    t = cyc;
    if (size != '0) begin
      model_run = 1'b1; model_num = num; model_win = 0; model_ovr = 1'b0;
    end
    tick(1);
    cmd_start = 1'b0;
  endtask

  task automatic pulse(input bit valid, input bit stop, output int unsigned t);
    count_data  = {$urandom, $urandom, $urandom, $urandom};
    count_valid = valid;
    cmd_stop    = stop;
    t = cyc;
    tick(1);
    count_valid = 1'b0;
    cmd_stop    = 1'b0;
    if (stop) model_run = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      tick(1);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_idle: busy=%b after %0d cycles, expected 0", name, busy, budget);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({window_size, start_counting, reset_counting, busy} !== '0) begin
      failures++;
      $display("FAIL reset_ctrl: ws=%h sc=%b rc=%b busy=%b expected 0",
               window_size, start_counting, reset_counting, busy);
    end
    checks++;
    if ({m_valid, m_data, m_channel, m_window_idx, m_last} !== '0) begin
      failures++;
      $display("FAIL reset_stream: v=%b d=%h ch=%0d idx=%0d last=%b expected 0",
               m_valid, m_data, m_channel, m_window_idx, m_last);
    end
    checks++;
    if ({overrun, cfg_err} !== 2'b00) begin
      failures++;
      $display("FAIL reset_flags: overrun=%b cfg_err=%b expected 0", overrun, cfg_err);
    end
  endtask

  task automatic test_basic();
    int unsigned t, tw;
    clear_model();
    m_ready = 1'b1;
    start_acq(WW'(50000), 3, t);
    tick(4);
    checks++;
    if (rc_q.size() != 1 || sc_q.size() != 1 || rc_q[0] != t + 1 || sc_q[0] != t + 2) begin
      failures++;
      $display("FAIL basic_pulses: rc=%p sc=%p, expected rc at %0d sc at %0d",
               rc_q, sc_q, t + 1, t + 2);
    end
    checks++;
    if (window_size !== WW'(50000) || busy !== 1'b1) begin
      failures++;
      $display("FAIL basic_cfg: ws=%0d busy=%b, expected 50000 busy=1", window_size, busy);
    end
    cfg_window_size = WW'(7);
    cmd_start = 1'b1;
    tick(1);
    cmd_start = 1'b0;
    for (int w = 0; w < 3; w++) begin
      tick(999);
      pulse(1'b1, 1'b0, tw);
    end
    wait_idle(50, "basic");
    checks++;
    if (window_size !== WW'(50000)) begin
      failures++;
      $display("FAIL basic_hold: ws=%0d expected 50000", window_size);
    end
    checks++;
    if (rc_q.size() != 2 || sc_q.size() != 1 || rc_q[1] != tw + 1) begin
      failures++;
      $display("FAIL basic_flush: rc=%p sc=%p, expected flush pulse at %0d", rc_q, sc_q, tw + 1);
    end
    checks++;
    if (overrun !== 1'b0) begin
      failures++;
      $display("FAIL basic_overrun: got %b expected 0", overrun);
    end
    checks++;
    if (obs_q.size() != 12) begin
      failures++;
      $display("FAIL basic_count: got %0d words expected 12", obs_q.size());
    end else begin
      checks++;
      if (obs_q[3][0] !== 1'b1 || obs_q[4][0] !== 1'b0 || obs_q[11][23:8] !== 16'd2) begin
        failures++;
        $display("FAIL basic_framing: w3=%h w4=%h w11=%h", obs_q[3], obs_q[4], obs_q[11]);
      end
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL basic_word%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_stop();
    int unsigned t, ts;
    clear_model();
    start_acq(WW'($urandom_range(1, 1000)), 0, t);
    rand_ready = 1'b1;
    tick(10);
    for (int w = 0; w < 5; w++) begin
      pulse(1'b1, 1'b0, t);
      tick(30 + int'($urandom_range(0, 9)));
    end
    pulse(1'b1, 1'b1, ts);
    rand_ready = 1'b0;
    m_ready = 1'b1;
    wait_idle(100, "stop");
    checks++;
    if (rc_q.size() != 2 || rc_q[rc_q.size()-1] != ts + 1) begin
      failures++;
      $display("FAIL stop_flush: rc=%p expected 2 pulses, last at %0d", rc_q, ts + 1);
    end
    checks++;
    if (overrun !== model_ovr) begin
      failures++;
      $display("FAIL stop_overrun: got %b expected %b", overrun, model_ovr);
    end
    checks++;
    if (obs_q.size() != 24 || obs_q[23][23:8] !== 16'd5) begin
      failures++;
      $display("FAIL stop_count: got %0d words expected 24 ending in window 5", obs_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL stop_word%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_overrun();
    int unsigned t;
    clear_model();
    m_ready = 1'b0;
    start_acq(WW'(300), 0, t);
    tick(10);
    pulse(1'b1, 1'b0, t);
    tick(3);
    pulse(1'b1, 1'b0, t);
    checks++;
    if (overrun !== 1'b1) begin
      failures++;
      $display("FAIL ovr_flag: got %b expected 1", overrun);
    end
    for (int i = 0; i < 18; i++) begin
      checks++;
      if (m_valid !== 1'b1 ||
          wkey(m_data, 32'(m_channel), 32'(m_window_idx), m_last) !== exp_q[0]) begin
        failures++;
        $display("FAIL ovr_hold%0d: v=%b d=%h ch=%0d, expected held %h",
                 i, m_valid, m_data, m_channel, exp_q[0]);
      end
      tick(1);
    end
    m_ready = 1'b1;
    tick(10);
    pulse(1'b1, 1'b0, t);
    tick(10);
    pulse(1'b0, 1'b1, t);
    wait_idle(50, "ovr");
    checks++;
    if (obs_q.size() != 8 || obs_q[4][23:8] !== 16'd2 || overrun !== 1'b1) begin
      failures++;
      $display("FAIL ovr_seq: %0d words, overrun=%b, expected 8 words, window 2 second, overrun=1",
               obs_q.size(), overrun);
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL ovr_word%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int unsigned t;
    clear_model();
    m_ready = 1'b1;
    start_acq(WW'(77), 0, t);
    tick(10);
    pulse(1'b1, 1'b0, t);
    tick(3);
    checks++;
    if (m_valid !== 1'b1 || m_last !== 1'b1) begin
      failures++;
      $display("FAIL b2b_last: v=%b last=%b expected 1/1", m_valid, m_last);
    end
    pulse(1'b1, 1'b0, t);
    checks++;
    if (m_valid !== 1'b1 || m_channel !== 2'd0 || m_window_idx !== 16'd1 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL b2b_next: v=%b ch=%0d idx=%0d ovr=%b, expected 1/0/1/0",
               m_valid, m_channel, m_window_idx, overrun);
    end
    tick(10);
    pulse(1'b0, 1'b1, t);
    wait_idle(50, "b2b");
    checks++;
    if (obs_q.size() != 8) begin
      failures++;
      $display("FAIL b2b_count: got %0d words expected 8", obs_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL b2b_word%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_cfg_err();
    int unsigned t;
    clear_model();
    start_acq('0, 2, t);
    tick(5);
    checks++;
    if (cfg_err !== 1'b1 || busy !== 1'b0 || rc_q.size() != 0 || sc_q.size() != 0) begin
      failures++;
      $display("FAIL cfgerr_reject: cfg_err=%b busy=%b rc=%0d sc=%0d, expected 1/0/0/0",
               cfg_err, busy, rc_q.size(), sc_q.size());
    end
    start_acq(WW'(100), 1, t);
    tick(2);
    checks++;
    if (cfg_err !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL cfgerr_clear: cfg_err=%b busy=%b expected 0/1", cfg_err, busy);
    end
    tick(5);
    pulse(1'b1, 1'b0, t);
    wait_idle(50, "cfgerr");
    checks++;
    if (obs_q.size() != 4 || obs_q.size() != exp_q.size() || (obs_q.size() == 4 && obs_q[3] !== exp_q[3])) begin
      failures++;
      $display("FAIL cfgerr_stream: got %0d words expected 4 matching the model", obs_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int unsigned t;
    clear_model();
    m_ready = 1'b1;
    start_acq(WW'(999), 0, t);
    tick(10);
    for (int w = 0; w < 3; w++) begin
      pulse(1'b1, 1'b0, t);
      if (w < 2) tick(10);
    end
    tick(1);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({m_valid, m_data, m_channel, m_window_idx, m_last} !== '0) begin
      failures++;
      $display("FAIL rstmid_stream: v=%b d=%h ch=%0d idx=%0d expected 0",
               m_valid, m_data, m_channel, m_window_idx);
    end
    checks++;
    if ({window_size, busy, reset_counting, start_counting} !== '0) begin
      failures++;
      $display("FAIL rstmid_ctrl: ws=%h busy=%b rc=%b sc=%b expected 0",
               window_size, busy, reset_counting, start_counting);
    end
    tick(1);
    clear_model();
    tick(2);
    rst_n = 1'b1;
    tick(3);
    checks++;
    if (rc_q.size() != 0 || sc_q.size() != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_quiet: rc=%0d sc=%0d busy=%b expected 0", rc_q.size(), sc_q.size(), busy);
    end
    start_acq(WW'(200), 1, t);
    tick(10);
    pulse(1'b1, 1'b0, t);
    wait_idle(50, "rstmid");
    checks++;
    if (obs_q.size() != 4 || obs_q[0][23:8] !== 16'd0) begin
      failures++;
      $display("FAIL rstmid_restart: %0d words, first idx not 0, expected 4 words from window 0",
               obs_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL rstmid_word%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    tick(3);
    test_reset();
    rst_n = 1'b1;
    tick(2);
    test_basic();
    test_stop();
    test_overrun();
    test_back_to_back();
    test_cfg_err();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
